// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the byte-addressed data memory.
// Latency: request sampled in IDLE at edge N, memory access in cycle N+1, ack in cycle N+2.
// Backpressure: one access in flight; other requests wait on their held req level, 1 access per 3 cycles.
//
// Ports:
//   i_clk, i_reset                 clock and asynchronous active-high reset
//   i_req/we/byte/addr/wdata{0,1}  request ports (0 = CPU load/store, 1 = loader/DMA), held until ack
//   o_ack{0,1}, o_err{0,1}         one-cycle completion pulse; err = out-of-range, memory untouched
//   o_rdata                        load result, valid with ack when err = 0
//   o_mem_*, o_MemRead/o_MemWrite  data-memory control pins (this block is their only driver)
//   i_mem_read_data                combinational memory read data (sign-extended on byte reads)
module dmem_arbiter #(
   parameter int unsigned MEM_BYTES = 1024,
   parameter int unsigned ADDR_W    = 32
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_req0,
   input  logic              i_req1,
   input  logic              i_we0,
   input  logic              i_we1,
   input  logic              i_byte0,
   input  logic              i_byte1,
   input  logic [ADDR_W-1:0] i_addr0,
   input  logic [ADDR_W-1:0] i_addr1,
   input  logic [31:0]       i_wdata0,
   input  logic [31:0]       i_wdata1,
   output logic              o_ack0,
   output logic              o_ack1,
   output logic              o_err0,
   output logic              o_err1,
   output logic [31:0]       o_rdata,
   output logic [ADDR_W-1:0] o_mem_address,
   output logic [31:0]       o_mem_write_data,
   output logic              o_MemRead,
   output logic              o_MemWrite,
   output logic              o_mem_byte,
   input  logic [31:0]       i_mem_read_data
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_REJECT, S_DONE} state_t;

   // Highest legal start address for each access size (no wrap-around).
   localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(MEM_BYTES - 1);
   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_prio;
   logic              r_owner;
   logic              r_we;
   logic              r_byte;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic              r_ack0, r_ack1, r_err0, r_err1;
   logic              r_mem_read, r_mem_write;
   logic [31:0]       r_rdata;

   logic              w_grant;
   logic              w_owner;
   logic              w_we;
   logic              w_byte;
   logic [ADDR_W-1:0] w_addr;
   logic [31:0]       w_wdata;
   logic              w_in_range;
   logic              w_finish;

   // Fields of the port that wins this cycle; only used when w_grant is high.
   assign w_we       = w_owner ? i_we1    : i_we0;
   assign w_byte     = w_owner ? i_byte1  : i_byte0;
   assign w_addr     = w_owner ? i_addr1  : i_addr0;
   assign w_wdata    = w_owner ? i_wdata1 : i_wdata0;
   assign w_in_range = w_byte ? (w_addr <= LAST_BYTE) : (w_addr <= LAST_WORD);
   assign w_finish   = (r_state == S_ACCESS) || (r_state == S_REJECT);

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_owner     = r_owner;
      case (r_state)
         S_IDLE: begin
            if (i_req0 || i_req1) begin
               w_grant     = 1'b1;
               // Contention goes to the favoured port; otherwise the lone requester wins.
               w_owner     = (i_req0 && i_req1) ? r_prio : i_req1;
               w_state_nxt = w_in_range ? S_ACCESS : S_REJECT;
            end
         end
         S_ACCESS: w_state_nxt = S_DONE;
         S_REJECT: w_state_nxt = S_DONE;
         S_DONE:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_prio      <= 1'b0;
         r_owner     <= 1'b0;
         r_we        <= 1'b0;
         r_byte      <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_ack0      <= 1'b0;
         r_ack1      <= 1'b0;
         r_err0      <= 1'b0;
         r_err1      <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_rdata     <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant) begin
            r_owner <= w_owner;
            r_prio  <= ~w_owner;
            r_we    <= w_we;
            r_byte  <= w_byte;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
         end
         // Strobes are registered one cycle ahead so they are high exactly in ACCESS.
         r_mem_read  <= w_grant && w_in_range && !w_we;
         r_mem_write <= w_grant && w_in_range && w_we;
         r_ack0      <= w_finish && !r_owner;
         r_ack1      <= w_finish &&  r_owner;
         r_err0      <= (r_state == S_REJECT) && !r_owner;
         r_err1      <= (r_state == S_REJECT) &&  r_owner;
         if ((r_state == S_ACCESS) && !r_we) begin
            r_rdata <= i_mem_read_data;
         end
      end
   end

   assign o_ack0           = r_ack0;
   assign o_ack1           = r_ack1;
   assign o_err0           = r_err0;
   assign o_err1           = r_err1;
   assign o_rdata          = r_rdata;
   assign o_mem_address    = r_addr;
   assign o_mem_write_data = r_wdata;
   assign o_mem_byte       = r_byte;
   assign o_MemRead        = r_mem_read;
   assign o_MemWrite       = r_mem_write;

endmodule
